c1541_gcr_stream: RTL
=====================

# c1541_gcr_stream

Drive-side bit engine for the 1541 model: rotates a byte-addressed GCR track image past a virtual head at the zone-dependent bit rate. It produces the read data byte, byte-ready and SYNC signals consumed by the drive logic (din, byte_n, sync_n), and writes the logic's output byte (dout) back into the track image in write mode. It sits between the drive logic and the track buffer RAM owned by the image loader.

## Interface
Parameters:
- BYTE_PULSE, 32: byte_n low time in clk32 cycles, which is one full drive CPU cycle.
- SYNC_ONES, 10: count of consecutive 1 bits that declares SYNC.

Ports:
- clk32  in  1  sole clock, 32 MHz.
- reset_n  in  1  reset; one clock, synchronous, active-low.
- mtr  in  1  spindle on; the engine is frozen when 0.
- mode  in  1  1 = read, 0 = write.
- soe  in  1  byte-ready enable.
- speed_zone  in  2  bit-rate zone.
- dout  in  8  byte to write.
- wps_n  in  1  0 = write-protected.
- track_len  in  13  track length in bytes; 0 = no disk.
- buf_rdata  in  8  track RAM read data, valid 1 cycle after buf_addr.
- din  out  8  last assembled read byte.
- byte_n  out  1  byte ready, active low.
- sync_n  out  1  SYNC detected, active low.
- buf_addr  out  13  current byte position.
- buf_wdata  out  8  byte to write.
- buf_we  out  1  one-cycle write strobe.

## Operation
- **Bit period.** P = 8*(16 - speed_zone) clk32 cycles: zone 0 = 128, zone 3 = 104.
  - A phase counter runs 0..P-1. The bit event occurs at phase P-1.
  - P is latched at each bit event, so a zone change takes effect from the next bit.
- **Head position.** Byte address plus bit index 7..0, MSB first.
  - At phase 2 of bit 7, cur_byte <= buf_rdata.
  - At the bit event of bit 0, the address increments. It wraps to 0 when addr+1 >= track_len.
  - If track_len changes so that addr >= track_len, addr <= 0 on the next cycle.
- **Read bit.** rbit = cur_byte[bit index].
  - The 10-bit history shifts left with rbit.
  - A byte shift register collects bits. bitcnt 0..7 counts assembled bits.
- **SYNC.**
  - sync_n = 0 while mode = 1 and the last SYNC_ONES read bits are all 1.
  - While sync is active, bitcnt is forced to 0 at each bit event and byte_n is not pulsed.
  - The bit that ends sync (a 0) is counted as the first bit of the next byte.
- **Byte complete (bitcnt wraps 7→0).**
  - din <= assembled byte.
  - If soe = 1, byte_n goes low for BYTE_PULSE cycles.
  - In write mode, wsr <= dout.
  - byte_n also pulses in write mode.
- **Write mode (mode = 0).**
  - Each bit event shifts out wsr[7] and replaces the current bit position of the merge register.
  - The merge register is loaded from cur_byte at phase 2 of bit 7.
  - At the bit event of bit 0, buf_wdata = merge and buf_we = 1 for one cycle, at the old address.
  - No buf_we is issued while wps_n = 0.
  - A partial byte at a mode switch keeps its unwritten bits.
- **Frozen state.** mtr = 0 or track_len = 0 freezes the phase counter, position and bitcnt, and forces byte_n = 1, sync_n = 1 and buf_we = 0. din is held.

## Timing
- **Reset values:** din = 0x00, byte_n = 1, sync_n = 1, buf_addr = 0, buf_wdata = 0x00, buf_we = 0. Internal counters, bit index 7 and history all zero.
- **Reset mid-operation** gives these values on the next clock edge. No pending write completes.
- **Update timing.** All outputs are registered.
  - din and byte_n change on the same edge, at the bit event + 1.
  - sync_n changes at the bit event + 1.
- **Overlapping byte pulses.** A new byte_n pulse occurring while one is still low restarts the pulse counter. This is unreachable at legal P.
- **Simultaneous events.**
  - Byte complete and sync onset on the same bit: sync wins and there is no pulse.
  - Write and wrap on the same bit: the write uses the pre-wrap address.

## Structure
- **Shared package c1541_pkg:**
  - zone_period() function.
  - Constants for BYTE_PULSE and SYNC_ONES defaults.
  - Track address width 13.
- **Sub-module c1541_bit_timer:** phase counter, P latch, bit-event and phase-2 strobes, mtr freeze.

## Test plan
1. **Read, zone 3.** mtr = 1, mode = 1, soe = 1, buffer all 0x55, track_len = 100 → byte_n low 32 cycles every 832 cycles; din = 0x55.
2. **SYNC.** Buffer FF FF 52 …, zone 0 → sync_n falls after the 10th one (bit event + 1) and rises after the first 0 bit. The next byte_n has din = 0x52. There is no pulse during sync.
3. **Write.** mode = 0, dout = 0xA5, wps_n = 1 → buf_we every 8 bit periods with buf_wdata = 0xA5. With wps_n = 0 → buf_we never asserted.
4. **Wrap.** track_len = 3 → buf_addr sequence 0, 1, 2, 0, 1. Shrinking track_len to 1 at addr 2 → addr 0 next cycle.
5. **Freeze.** mtr dropped mid-byte → phase counter frozen, byte_n = 1. mtr restored → bits resume at the same bit index, and the byte completes after the remaining bits.
6. **soe = 0 and reset.** soe = 0 → din updates and byte_n stays 1. reset_n low mid-byte → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/c1541_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | c1541_pkg : shared constants and zone timing for the GCR engine   |
// | Revision  : 1.0                                                   |
// +------------------------------------------------------------------+
package c1541_pkg;

    localparam int ADDR_W         = 13;
    localparam int DEF_BYTE_PULSE = 32;
    localparam int DEF_SYNC_ONES  = 10;

    // Bit period in clk32 cycles: 8 * (16 - zone).
    function automatic logic [7:0] zone_period(input logic [1:0] zone);
        return {5'd16 - {3'b000, zone}, 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/c1541_bit_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | c1541_bit_timer : per-bit phase counter with latched bit period   |
// | Revision        : 1.0                                             |
// +------------------------------------------------------------------+
module c1541_bit_timer
    import c1541_pkg::*;
(
    input  logic       clk32,
    input  logic       reset_n,
    input  logic       run,
    input  logic [1:0] speed_zone,
    output logic       bit_evt,
    output logic       phase2
);

    logic [7:0] phase;
    logic [7:0] period;

    // The period is only re-sampled at a bit boundary so a zone change never splits a bit.
    always_ff @(posedge clk32) begin
        if (!reset_n) begin
            phase  <= 8'd0;
            period <= zone_period(speed_zone);
        end else if (run) begin
            if (phase == period - 8'd1) begin
                phase  <= 8'd0;
                period <= zone_period(speed_zone);
            end else begin
                phase  <= phase + 8'd1;
            end
        end
    end

    assign bit_evt = run && (phase == period - 8'd1);
    assign phase2  = run && (phase == 8'd2);

endmodule
`default_nettype wire

// File: rtl/c1541_gcr_stream.sv
`default_nettype none
// +------------------------------------------------------------------+
// | c1541_gcr_stream : rotates a GCR track image past a virtual head  |
// | Revision         : 1.0                                            |
// +------------------------------------------------------------------+
module c1541_gcr_stream
    import c1541_pkg::*;
#(
    parameter int BYTE_PULSE = DEF_BYTE_PULSE,
    parameter int SYNC_ONES  = DEF_SYNC_ONES
) (
    input  logic              clk32,
    input  logic              reset_n,
    input  logic              mtr,
    input  logic              mode,
    input  logic              soe,
    input  logic [1:0]        speed_zone,
    input  logic [7:0]        dout,
    input  logic              wps_n,
    input  logic [ADDR_W-1:0] track_len,
    input  logic [7:0]        buf_rdata,
    output logic [7:0]        din,
    output logic              byte_n,
    output logic              sync_n,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic              buf_we
);

    localparam int PW = $clog2(BYTE_PULSE + 1);

    logic                 run;
    logic                 bit_evt;
    logic                 phase2;
    logic [ADDR_W-1:0]    addr;
    logic [ADDR_W-1:0]    addr_next;
    logic [2:0]           bitidx;
    logic [2:0]           bitcnt;
    logic [7:0]           cur_byte;
    logic [7:0]           shreg;
    logic [7:0]           wsr;
    logic [7:0]           merge;
    logic [SYNC_ONES-1:0] hist;
    logic [PW-1:0]        pcnt;

    logic                 rbit;
    logic [SYNC_ONES-1:0] hist_next;
    logic                 sync_now;
    logic [7:0]           shreg_next;
    logic [7:0]           merge_next;
    logic                 byte_done;
    logic                 last_bit;
    logic                 write_now;
    logic                 wrap;

    assign run = mtr && (track_len != '0);

    c1541_bit_timer u_bit_timer (
        .clk32      (clk32),
        .reset_n    (reset_n),
        .run        (run),
        .speed_zone (speed_zone),
        .bit_evt    (bit_evt),
        .phase2     (phase2)
    );

    always_comb begin
        rbit       = cur_byte[bitidx];
        hist_next  = {hist[SYNC_ONES-2:0], rbit};
        sync_now   = mode && (&hist_next);
        shreg_next = {shreg[6:0], rbit};
        merge_next = merge;
        merge_next[bitidx] = wsr[7];
        byte_done  = bit_evt && !sync_now && (bitcnt == 3'd7);
        last_bit   = bit_evt && (bitidx == 3'd0);
        write_now  = last_bit && !mode && wps_n;
        wrap       = ({1'b0, addr} + 14'd1) >= {1'b0, track_len};
        addr_next  = addr;
        if ((track_len != '0) && (addr >= track_len)) begin
            addr_next = '0;
        end else if (last_bit) begin
            addr_next = wrap ? '0 : addr + 13'd1;
        end
    end

    always_ff @(posedge clk32) begin
        if (!reset_n) begin
            addr      <= '0;
            buf_addr  <= '0;
            bitidx    <= 3'd7;
            bitcnt    <= 3'd0;
            cur_byte  <= 8'h00;
            shreg     <= 8'h00;
            wsr       <= 8'h00;
            merge     <= 8'h00;
            hist      <= '0;
            pcnt      <= '0;
            din       <= 8'h00;
            byte_n    <= 1'b1;
            sync_n    <= 1'b1;
            buf_wdata <= 8'h00;
            buf_we    <= 1'b0;
        end else begin
            buf_we <= 1'b0;
            addr   <= addr_next;
            // Hold the old address for the write-back cycle; the read of the new byte lags one cycle.
            buf_addr <= write_now ? addr : addr_next;
            if (phase2 && (bitidx == 3'd7)) begin
                cur_byte <= buf_rdata;
                merge    <= buf_rdata;
            end
            if (bit_evt) begin
                bitidx <= bitidx - 3'd1;
                hist   <= hist_next;
                shreg  <= shreg_next;
                sync_n <= !sync_now;
                bitcnt <= sync_now ? 3'd0 : bitcnt + 3'd1;
                if (!mode) begin
                    merge <= merge_next;
                    wsr   <= {wsr[6:0], 1'b0};
                end
                if (write_now) begin
                    buf_wdata <= merge_next;
                    buf_we    <= 1'b1;
                end
                if (byte_done) begin
                    din <= shreg_next;
                    if (!mode) begin
                        wsr <= dout;
                    end
                end
            end
            if (byte_done && soe) begin
                byte_n <= 1'b0;
                pcnt   <= PW'(BYTE_PULSE - 1);
            end else if (!byte_n) begin
                if (pcnt == '0) begin
                    byte_n <= 1'b1;
                end else begin
                    pcnt <= pcnt - 1'b1;
                end
            end
            if (!run) begin
                byte_n <= 1'b1;
                sync_n <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
